matrix_mult_param: RTL and testbench

- Parametrised successor to the fixed 8x8 T/S matrix engine.
- Computes R = A x B, or R = A x Bᵀ selected per run, for signed N x N matrices.
- Reads operands from two external synchronous-read RAM ports and writes results row-major to a third RAM port.
- Sits between the dequantiser/C-matrix RAMs and the IDCT write-back stage; the top-level FSM drives it with a start/done handshake.

---
 rtl/matrix_mult_param.sv | 141 ++++++++++++++
 tb/tb_matrix_mult_param.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_param.sv
// Signed N x N matrix multiplier R = A x B or A x B^T over synchronous-read RAM ports.
// Optional macro MATRIX_MULT_ROUND_EN selects round-half-up instead of floor on the scale shift.
module matrix_mult_param #(
    parameter int unsigned N     = 8,
    parameter int unsigned DW    = 16,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 8,
    localparam int unsigned AW   = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic             CLOCK_50_I,
    input  logic             Reset,
    input  logic             start,
    input  logic             transpose_b,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    a_addr,
    input  logic [DW-1:0]    a_rdata,
    output logic [AW-1:0]    b_addr,
    input  logic [DW-1:0]    b_rdata,
    output logic [AW-1:0]    r_addr,
    output logic [OUT_W-1:0] r_wdata,
    output logic             r_we
);

    localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ACC_W = 2 * DW + $clog2(N);
    localparam logic [CW-1:0] Last = CW'(N - 1);

    // Saturation limits held in ACC_W+1 bits; assumes OUT_W <= ACC_W.
    localparam logic signed [ACC_W:0] MaxV =
        $signed({{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}});
    localparam logic signed [ACC_W:0] MinV =
        $signed({{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}});

    typedef enum logic [2:0] {StIdle, StMac, StDrain, StWrite, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    tr_q, tr_d;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W:0]   acc_x, scaled;

    assign prod = $signed(a_rdata) * $signed(b_rdata);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        tr_d    = tr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tr_d    = transpose_b;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                // Read data lags the address by one cycle, so k=0 has nothing to add yet.
                acc_d = (k_q == '0) ? '0 : acc_q + ACC_W'(prod);
                if (k_q == Last) begin
                    state_d = StDrain;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            StDrain: begin
                acc_d   = acc_q + ACC_W'(prod);
                state_d = StWrite;
            end
            StWrite: begin
                k_d     = '0;
                state_d = StMac;
                if (j_q == Last) begin
                    j_d = '0;
                    if (i_q == Last) begin
                        state_d = StDone;
                    end else begin
                        i_d = i_q + CW'(1);
                    end
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            tr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            tr_q    <= tr_d;
        end
    end

    assign a_addr = AW'(32'(i_q) * N + 32'(k_q));
    assign b_addr = tr_q ? AW'(32'(j_q) * N + 32'(k_q)) : AW'(32'(k_q) * N + 32'(j_q));
    assign r_addr = AW'(32'(i_q) * N + 32'(j_q));

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign r_we = (state_q == StWrite);

`ifdef MATRIX_MULT_ROUND_EN
    localparam logic signed [ACC_W:0] RndInc =
        (SHIFT > 0) ? (ACC_W + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0) : '0;
    assign acc_x = $signed({acc_q[ACC_W-1], acc_q}) + RndInc;
`else
    assign acc_x = $signed({acc_q[ACC_W-1], acc_q});
`endif

    assign scaled = acc_x >>> SHIFT;

    always_comb begin
        r_wdata = scaled[OUT_W-1:0];
        if (scaled > MaxV) begin
            r_wdata = MaxV[OUT_W-1:0];
        end else if (scaled < MinV) begin
            r_wdata = MinV[OUT_W-1:0];
        end
    end

endmodule

// File: tb/tb_matrix_mult_param.sv
// Self-checking bench for matrix_mult_param (N=3, DW=8, OUT_W=10, SHIFT=3) against an
// arithmetic reference model; honours MATRIX_MULT_ROUND_EN the same way as the design.
module tb_matrix_mult_param;

    localparam int unsigned N     = 3;
    localparam int unsigned DW    = 8;
    localparam int unsigned OUT_W = 10;
    localparam int unsigned SHIFT = 3;
    localparam int unsigned AW    = 4;
    localparam int unsigned NN    = N * N;
    localparam int RUN_CYC        = NN * (N + 2) + 1;

    logic             clk = 1'b0;
    logic             rst, start, tr;
    logic             busy, done, r_we;
    logic [AW-1:0]    a_addr, b_addr, r_addr;
    logic [DW-1:0]    a_rdata, b_rdata;
    logic [OUT_W-1:0] r_wdata;

    logic signed [DW-1:0] a_mem[16];
    logic signed [DW-1:0] b_mem[16];
    logic [OUT_W-1:0]     r_mem[16];
    bit                   r_seen[16];
    int wr_cnt, dup_cnt, oob_cnt, done_cnt;
    int exp_r[NN];
    int total = 0;
    int bad   = 0;
    int done_cyc, busy_first, busy_after;

    always #5 clk = ~clk;

    matrix_mult_param #(.N(N), .DW(DW), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .CLOCK_50_I (clk),
        .Reset      (rst),
        .start      (start),
        .transpose_b(tr),
        .busy       (busy),
        .done       (done),
        .a_addr     (a_addr),
        .a_rdata    (a_rdata),
        .b_addr     (b_addr),
        .b_rdata    (b_rdata),
        .r_addr     (r_addr),
        .r_wdata    (r_wdata),
        .r_we       (r_we)
    );

    always @(posedge clk) begin
        a_rdata <= a_mem[a_addr];
        b_rdata <= b_mem[b_addr];
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (r_we) begin
            wr_cnt++;
            if (r_addr >= NN) oob_cnt++;
            else begin
                if (r_seen[r_addr]) dup_cnt++;
                r_seen[r_addr] = 1'b1;
                r_mem[r_addr]  = r_wdata;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        wr_cnt = 0; dup_cnt = 0; oob_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            r_seen[i] = 1'b0;
            r_mem[i]  = '0;
        end
    endtask

    function automatic int scale(input longint acc_in);
        longint acc, v, hi, lo;
        acc = acc_in;
`ifdef MATRIX_MULT_ROUND_EN
        if (SHIFT > 0) acc = acc + (64'sd1 <<< (SHIFT - 1));
`endif
        v  = acc >>> SHIFT;
        hi = (64'sd1 <<< (OUT_W - 1)) - 1;
        lo = -(64'sd1 <<< (OUT_W - 1));
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return int'(v);
    endfunction

    function automatic void model(input bit t);
        longint acc;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++)
                    acc += longint'(a_mem[i*N+k]) *
                           longint'(t ? b_mem[j*N+k] : b_mem[k*N+j]);
                exp_r[i*N+j] = scale(acc);
            end
        end
    endfunction

    task automatic fill_random(input int m);
        for (int i = 0; i < NN; i++) begin
            a_mem[i] = DW'(int'($urandom_range(0, 2 * m)) - m);
            b_mem[i] = DW'(int'($urandom_range(0, 2 * m)) - m);
        end
    endtask

    // Drives one run; optionally re-pulses start in cycle poke_cyc and in the done cycle.
    task automatic do_run(input bit t, input int poke_cyc, input bit poke_done);
        int cyc;
        clear_log();
        tr = t;
        start = 1'b1;
        step();
        busy_first = busy;
        done_cyc = -1;
        cyc = 1;
        while (cyc <= RUN_CYC + 20 && done_cyc < 0) begin
            start = (cyc == poke_cyc);
            tr = ~t;
            if (done) begin
                done_cyc = cyc;
                start = poke_done;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        tr = t;
        busy_after = busy;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; tr = 1'b0;
        step(); step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (r_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", r_we); end
        total++; if ({a_addr, b_addr, r_addr} !== '0) begin bad++;
            $display("FAIL reset_addr: got %h/%h/%h want 0", a_addr, b_addr, r_addr); end
        total++; if (r_wdata !== '0) begin bad++; $display("FAIL reset_wdata: got %0d want 0", r_wdata); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_normal(input bit t, input int m, input bit directed);
        if (directed) begin
            for (int i = 0; i < NN; i++) begin
                a_mem[i] = DW'(i + 1);
                b_mem[i] = DW'(9 - i);
            end
        end else fill_random(m);
        model(t);
        do_run(t, 0, 1'b0);
        total++; if (done_cyc !== RUN_CYC) begin bad++;
            $display("FAIL mult_done_cycle: got %0d want %0d", done_cyc, RUN_CYC); end
        total++; if (busy_first !== 1 || busy_after !== 0) begin bad++;
            $display("FAIL mult_busy: got %0d/%0d want 1/0", busy_first, busy_after); end
        total++; if (wr_cnt !== NN || dup_cnt !== 0 || oob_cnt !== 0) begin bad++;
            $display("FAIL mult_writes: got %0d dup %0d oob %0d want %0d", wr_cnt, dup_cnt, oob_cnt, NN); end
        for (int i = 0; i < NN; i++) begin
            total++; if (int'($signed(r_mem[i])) !== exp_r[i]) begin bad++;
                $display("FAIL mult_r[%0d] t=%0d: got %0d want %0d", i, t, $signed(r_mem[i]), exp_r[i]); end
        end
    endtask

    task automatic test_saturation;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NN; i++) begin
                a_mem[i] = (s == 0) ? 8'sd127 : -8'sd128;
                b_mem[i] = 8'sd127;
            end
            do_run(1'b0, 0, 1'b0);
            for (int i = 0; i < NN; i++) begin
                total++; if (int'($signed(r_mem[i])) !== ((s == 0) ? 511 : -512)) begin bad++;
                    $display("FAIL sat_r[%0d]: got %0d want %0d", i, $signed(r_mem[i]),
                             (s == 0) ? 511 : -512); end
            end
        end
    endtask

    task automatic test_rounding;
        int want_pos, want_neg;
`ifdef MATRIX_MULT_ROUND_EN
        want_pos = 1; want_neg = 0;
`else
        want_pos = 0; want_neg = -1;
`endif
        for (int i = 0; i < 16; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
        a_mem[0] = 8'sd2; a_mem[1] = 8'sd1; b_mem[0] = 8'sd1; b_mem[3] = 8'sd2;  // acc00 = 4
        do_run(1'b0, 0, 1'b0);
        total++; if (int'($signed(r_mem[0])) !== want_pos) begin bad++;
            $display("FAIL round_pos: got %0d want %0d", $signed(r_mem[0]), want_pos); end
        a_mem[0] = -8'sd2; a_mem[1] = -8'sd1;
        do_run(1'b0, 0, 1'b0);
        total++; if (int'($signed(r_mem[0])) !== want_neg) begin bad++;
            $display("FAIL round_neg: got %0d want %0d", $signed(r_mem[0]), want_neg); end
    endtask

    task automatic test_handshake;
        fill_random(40);
        model(1'b1);
        do_run(1'b1, 5, 1'b1);
        step(); step(); step();
        total++; if (done_cnt !== 1 || done_cyc !== RUN_CYC) begin bad++;
            $display("FAIL hs_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc, RUN_CYC); end
        total++; if (busy !== 1'b0 || busy_after !== 0) begin bad++;
            $display("FAIL hs_idle: got busy %b/%0d want 0", busy, busy_after); end
        for (int i = 0; i < NN; i++) begin
            total++; if (int'($signed(r_mem[i])) !== exp_r[i]) begin bad++;
                $display("FAIL hs_r[%0d]: got %0d want %0d", i, $signed(r_mem[i]), exp_r[i]); end
        end
    endtask

    task automatic test_back_to_back;
        fill_random(20);
        do_run(1'b0, 0, 1'b0);
        model(1'b1);
        do_run(1'b1, 0, 1'b0);  // start raised in the IDLE cycle right after done
        total++; if (done_cyc !== RUN_CYC || wr_cnt !== NN) begin bad++;
            $display("FAIL b2b_run: got done %0d writes %0d want %0d/%0d", done_cyc, wr_cnt, RUN_CYC, NN); end
        for (int i = 0; i < NN; i++) begin
            total++; if (int'($signed(r_mem[i])) !== exp_r[i]) begin bad++;
                $display("FAIL b2b_r[%0d]: got %0d want %0d", i, $signed(r_mem[i]), exp_r[i]); end
        end
    endtask

    task automatic test_reset_midrun;
        int w_at_reset;
        fill_random(128);
        clear_log();
        tr = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 20; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (busy !== 1'b0 || r_we !== 1'b0 || done !== 1'b0) begin bad++;
            $display("FAIL midrst_state: got busy %b we %b done %b want 0", busy, r_we, done); end
        total++; if (a_addr !== '0 || r_addr !== '0) begin bad++;
            $display("FAIL midrst_addr: got %0d/%0d want 0", a_addr, r_addr); end
        w_at_reset = wr_cnt;
        for (int c = 0; c < 60; c++) step();
        total++; if (done_cnt !== 0 || wr_cnt !== w_at_reset) begin bad++;
            $display("FAIL midrst_quiet: got done %0d writes %0d want 0/%0d", done_cnt, wr_cnt, w_at_reset); end
        model(1'b0);
        do_run(1'b0, 0, 1'b0);
        total++; if (done_cyc !== RUN_CYC || wr_cnt !== NN) begin bad++;
            $display("FAIL midrst_rerun: got done %0d writes %0d want %0d/%0d", done_cyc, wr_cnt, RUN_CYC, NN); end
        for (int i = 0; i < NN; i++) begin
            total++; if (int'($signed(r_mem[i])) !== exp_r[i]) begin bad++;
                $display("FAIL midrst_r[%0d]: got %0d want %0d", i, $signed(r_mem[i]), exp_r[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
        clear_log();
        test_reset();
        test_normal(1'b0, 0, 1'b1);
        test_normal(1'b1, 0, 1'b1);
        for (int r = 0; r < 4; r++) test_normal(r[0], 128, 1'b0);
        for (int r = 0; r < 4; r++) test_normal(r[0], 12, 1'b0);
        test_saturation();
        test_rounding();
        test_handshake();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
